// File: rtl/fft8_seq_if.sv
// rtl/fft8_seq_if.sv - sample-in / spectrum-out handshake bundle for fft8_seq
interface fft8_seq_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fft8_seq.sv
// rtl/fft8_seq.sv - 8-point radix-2 FFT, one shared butterfly over an 8-entry register file
module fft8_seq #(
  parameter int DW      = 32,
  parameter int BF_PIPE = 1
) (
  input  logic          ck,
  input  logic          rst_n,
  fft8_seq_if.slave     bus,
  input  logic [DW-1:0] W0,
  input  logic [DW-1:0] W1,
  input  logic [DW-1:0] W2,
  input  logic [DW-1:0] W3,
  output logic          busy
);

  localparam int HW = DW / 2;

  typedef enum logic [1:0] {
    S_LOAD,
    S_CALC,
    S_OUT
  } state_t;

  // Sign-magnitude Q4.11 multiply: magnitudes multiplied, bits [26:11] kept, sign reapplied.
  function automatic logic [HW-1:0] f_qmul(input logic [HW-1:0] a, input logic [HW-1:0] b);
    logic [HW-1:0] ma;
    logic [HW-1:0] mb;
    logic [HW-1:0] mag;
    ma  = a[HW-1] ? (~a + 16'd1) : a;
    mb  = b[HW-1] ? (~b + 16'd1) : b;
    mag = 16'(({16'd0, ma} * {16'd0, mb}) >> 11);
    return (a[HW-1] ^ b[HW-1]) ? (~mag + 16'd1) : mag;
  endfunction

  function automatic logic [2:0] f_bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [DW-1:0] r_mem [8];
  logic [DW-1:0] r_w [4];
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_out_last;
  logic [DW-1:0] r_out_data;
  logic          r_busy;

  logic [2:0]    w_a;
  logic [2:0]    w_b;
  logic [1:0]    w_ws;
  logic          w_issue;
  logic          w_calc_done;
  logic          w_load_acc;
  logic [2:0]    w_nxt;

  logic [DW-1:0] w_x0;
  logic [DW-1:0] w_x1;
  logic [DW-1:0] w_tw;
  logic [HW-1:0] w_rr;
  logic [HW-1:0] w_ii;
  logic [HW-1:0] w_ri;
  logic [HW-1:0] w_ir;
  logic [HW-1:0] w_tre;
  logic [HW-1:0] w_tim;
  logic [DW-1:0] w_y0;
  logic [DW-1:0] w_y1;

  logic          w_wb_en;
  logic [2:0]    w_wb_a;
  logic [2:0]    w_wb_b;
  logic [DW-1:0] w_wb_y0;
  logic [DW-1:0] w_wb_y1;

  // In-place schedule; consecutive ops never touch each other's operands, so a
  // one-cycle write-back delay needs no forwarding.
  always_comb begin
    w_a  = 3'd0;
    w_b  = 3'd0;
    w_ws = 2'd0;
    case (r_cnt)
      4'd0:    {w_a, w_b, w_ws} = {3'd0, 3'd4, 2'd0};
      4'd1:    {w_a, w_b, w_ws} = {3'd2, 3'd6, 2'd0};
      4'd2:    {w_a, w_b, w_ws} = {3'd1, 3'd5, 2'd0};
      4'd3:    {w_a, w_b, w_ws} = {3'd3, 3'd7, 2'd0};
      4'd4:    {w_a, w_b, w_ws} = {3'd0, 3'd2, 2'd0};
      4'd5:    {w_a, w_b, w_ws} = {3'd4, 3'd6, 2'd2};
      4'd6:    {w_a, w_b, w_ws} = {3'd1, 3'd3, 2'd0};
      4'd7:    {w_a, w_b, w_ws} = {3'd5, 3'd7, 2'd2};
      4'd8:    {w_a, w_b, w_ws} = {3'd0, 3'd1, 2'd0};
      4'd9:    {w_a, w_b, w_ws} = {3'd4, 3'd5, 2'd1};
      4'd10:   {w_a, w_b, w_ws} = {3'd2, 3'd3, 2'd2};
      4'd11:   {w_a, w_b, w_ws} = {3'd6, 3'd7, 2'd3};
      default: {w_a, w_b, w_ws} = {3'd0, 3'd0, 2'd0};
    endcase
  end

  assign w_issue     = (r_state == S_CALC) && (r_cnt < 4'd12);
  assign w_calc_done = (r_state == S_CALC) && (r_cnt == 4'(11 + BF_PIPE));
  assign w_load_acc  = (r_state == S_LOAD) && r_in_ready && bus.in_valid;
  assign w_nxt       = r_cnt[2:0] + 3'd1;

  assign w_x0  = r_mem[w_a];
  assign w_x1  = r_mem[w_b];
  assign w_tw  = r_w[w_ws];

  assign w_rr  = f_qmul(w_x1[DW-1:HW], w_tw[DW-1:HW]);
  assign w_ii  = f_qmul(w_x1[HW-1:0],  w_tw[HW-1:0]);
  assign w_ri  = f_qmul(w_x1[DW-1:HW], w_tw[HW-1:0]);
  assign w_ir  = f_qmul(w_x1[HW-1:0],  w_tw[DW-1:HW]);
  assign w_tre = w_rr - w_ii;
  assign w_tim = w_ri + w_ir;
  assign w_y0  = {w_x0[DW-1:HW] + w_tre, w_x0[HW-1:0] + w_tim};
  assign w_y1  = {w_x0[DW-1:HW] - w_tre, w_x0[HW-1:0] - w_tim};

  if (BF_PIPE == 0) begin : g_wb_comb
    assign w_wb_en = w_issue;
    assign w_wb_a  = w_a;
    assign w_wb_b  = w_b;
    assign w_wb_y0 = w_y0;
    assign w_wb_y1 = w_y1;
  end else begin : g_wb_pipe
    logic          r_p_vld;
    logic [2:0]    r_p_a;
    logic [2:0]    r_p_b;
    logic [DW-1:0] r_p_y0;
    logic [DW-1:0] r_p_y1;

    always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
        r_p_vld <= 1'b0;
        r_p_a   <= '0;
        r_p_b   <= '0;
        r_p_y0  <= '0;
        r_p_y1  <= '0;
      end else begin
        r_p_vld <= w_issue;
        if (w_issue) begin
          r_p_a  <= w_a;
          r_p_b  <= w_b;
          r_p_y0 <= w_y0;
          r_p_y1 <= w_y1;
        end
      end
    end

    assign w_wb_en = r_p_vld;
    assign w_wb_a  = r_p_a;
    assign w_wb_b  = r_p_b;
    assign w_wb_y0 = r_p_y0;
    assign w_wb_y1 = r_p_y1;
  end

  // Register file is deliberately left out of reset.
  always_ff @(posedge ck) begin
    if (w_load_acc) begin
      r_mem[r_cnt[2:0]] <= bus.in_data;
    end else if (w_wb_en) begin
      r_mem[w_wb_a] <= w_wb_y0;
      r_mem[w_wb_b] <= w_wb_y1;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      for (int i = 0; i < 4; i++) r_w[i] <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_load_acc) begin
            if (r_cnt == 4'd7) begin
              r_state    <= S_CALC;
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_w[0]     <= W0;
              r_w[1]     <= W1;
              r_w[2]     <= W2;
              r_w[3]     <= W3;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_CALC: begin
          if (w_calc_done) begin
            r_state     <= S_OUT;
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_out_data  <= r_mem[0];
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_OUT: begin
          // Bit-reversed read order turns the in-place result into natural frequency order.
          if (r_out_valid && bus.out_ready) begin
            if (r_cnt == 4'd7) begin
              r_state     <= S_LOAD;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_data  <= '0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_cnt      <= r_cnt + 4'd1;
              r_out_data <= r_mem[f_bitrev3(w_nxt)];
              r_out_last <= (r_cnt == 4'd6);
            end
          end
        end
        default: begin
          r_state <= S_LOAD;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign busy          = r_busy;

endmodule

// File: tb/tb_fft8_seq.sv
// tb/tb_fft8_seq.sv - directed bench for fft8_seq with a butt2-array reference
module tb_fft8_seq;
  localparam int BF_PIPE = 1;
  localparam int LAT     = 12 + BF_PIPE;
  localparam int PERIOD  = 8 + 12 + BF_PIPE + 8;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] w0, w1, w2, w3;
  logic        busy;

  fft8_seq_if #(.DW(32)) bus ();

  fft8_seq #(.DW(32), .BF_PIPE(BF_PIPE)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus),
    .W0    (w0),
    .W1    (w1),
    .W2    (w2),
    .W3    (w3),
    .busy  (busy)
  );

  always #5 ck = ~ck;

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] smp_q [16];
  logic [31:0] exp_q [16];
  logic [31:0] got_q [16];
  logic [31:0] tw_nom [4];
  logic [31:0] sine_q [8];
  int          acc_cyc [2];
  int          first_v_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, expv);
  endtask

  task automatic near(input string tag, input logic [15:0] v, input logic [15:0] t, input int tol);
    int d;
    d = int'($signed(v)) - int'($signed(t));
    if (d < 0) d = -d;
    chk(tag, (d <= tol) ? 32'(t) : 32'(v), 32'(t));
  endtask

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    int r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = ((sa < 0 ? -sa : sa) * (sb < 0 ? -sb : sb)) >>> 11;
    if ((sa < 0) != (sb < 0)) r = -r;
    return r[15:0];
  endfunction

  // Decimation-in-time loop form of the 12-butterfly array, nominal twiddles.
  task automatic golden(input int base);
    logic [31:0] v [8];
    logic [31:0] a;
    logic [31:0] w;
    logic [15:0] tr;
    logic [15:0] ti;
    int          span;
    int          j;
    int          wi;
    for (int i = 0; i < 8; i++) v[i] = smp_q[base + i];
    for (int s = 0; s < 3; s++) begin
      span = 4 >> s;
      for (int i = 0; i < 8; i++) begin
        if ((i & span) == 0) begin
          j = i + span;
          if (s == 0)      wi = 0;
          else if (s == 1) wi = (i >= 4) ? 2 : 0;
          else             wi = (((i >> 1) & 1) << 1) | ((i >> 2) & 1);
          w  = tw_nom[wi];
          tr = m_mul(v[j][31:16], w[31:16]) - m_mul(v[j][15:0], w[15:0]);
          ti = m_mul(v[j][31:16], w[15:0]) + m_mul(v[j][15:0], w[31:16]);
          a  = v[i];
          v[i] = {a[31:16] + tr, a[15:0] + ti};
          v[j] = {a[31:16] - tr, a[15:0] - ti};
        end
      end
    end
    for (int k = 0; k < 8; k++) exp_q[base + k] = v[((k & 1) << 2) | (k & 2) | ((k >> 2) & 1)];
  endtask

  task automatic send(input int n, input string nm);
    int   i = 0;
    int   g = 0;
    int   ov = 0;
    logic acc;
    while (i < n && g < 4000) begin
      @(negedge ck);
      g++;
      bus.in_valid = 1'b1;
      bus.in_data  = smp_q[i];
      acc = bus.in_ready;
      if (acc && bus.out_valid) ov++;
      if (acc && (i % 8) == 7) acc_cyc[i / 8] = cyc;
      @(posedge ck);
      if (acc) i++;
    end
    @(negedge ck);
    bus.in_valid = 1'b0;
    chk({nm, "_in_count"}, 32'(i), 32'(n));
    chk({nm, "_overlap"}, 32'(ov), 32'd0);
  endtask

  task automatic recv(input int n, input bit rnd, input string nm);
    int          k = 0;
    int          g = 0;
    int          stall_bad = 0;
    int          rdy_bad = 0;
    bit          seen = 0;
    logic        held_v = 1'b0;
    logic [31:0] held_d = '0;
    logic        held_l = 1'b0;
    while (k < n && g < 4000) begin
      @(negedge ck);
      g++;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held_v && (!bus.out_valid || bus.out_data !== held_d || bus.out_last !== held_l)) stall_bad++;
      if (busy && bus.in_ready) rdy_bad++;
      if (bus.out_valid && !seen) begin
        seen = 1;
        first_v_cyc = cyc;
      end
      held_v = bus.out_valid && !bus.out_ready;
      held_d = bus.out_data;
      held_l = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        got_q[k] = bus.out_data;
        chk($sformatf("%s_F%0d", nm, k), bus.out_data, exp_q[k]);
        chk($sformatf("%s_last%0d", nm, k), 32'(bus.out_last), 32'((k % 8) == 7));
        k++;
      end
    end
    chk({nm, "_out_count"}, 32'(k), 32'(n));
    chk({nm, "_stall_stable"}, 32'(stall_bad), 32'd0);
    chk({nm, "_in_ready_busy"}, 32'(rdy_bad), 32'd0);
  endtask

  task automatic set_nominal_w();
    w0 = tw_nom[0];
    w1 = tw_nom[1];
    w2 = tw_nom[2];
    w3 = tw_nom[3];
  endtask

  task automatic load_impulse(input int base);
    for (int i = 0; i < 8; i++) begin
      smp_q[base + i] = (i == 0) ? 32'h0800_0000 : 32'h0;
      exp_q[base + i] = 32'h0800_0000;
    end
  endtask

  task automatic load_dc(input int base);
    for (int i = 0; i < 8; i++) begin
      smp_q[base + i] = 32'h0100_0000;
      exp_q[base + i] = (i == 0) ? 32'h0800_0000 : 32'h0;
    end
  endtask

  task automatic load_sine(input int base);
    for (int i = 0; i < 8; i++) smp_q[base + i] = sine_q[i];
    golden(base);
  endtask

  initial begin
    tw_nom[0] = 32'h0800_0000;
    tw_nom[1] = 32'h05A8_FA58;
    tw_nom[2] = 32'h0000_F800;
    tw_nom[3] = 32'hFA58_FA58;
    sine_q[0] = 32'h0000_0000;
    sine_q[1] = 32'h075A_0000;
    sine_q[2] = 32'h0A66_0000;
    sine_q[3] = 32'h075A_0000;
    sine_q[4] = 32'h0000_0000;
    sine_q[5] = 32'hF8A6_0000;
    sine_q[6] = 32'hF59A_0000;
    sine_q[7] = 32'hF8A6_0000;
    set_nominal_w();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge ck);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", bus.out_data, 32'h0);
    rst_n = 1'b1;

    load_impulse(0);
    fork
      send(8, "imp");
      recv(8, 1'b0, "imp");
    join
    chk("imp_latency", 32'(first_v_cyc - acc_cyc[0] - 1), 32'(LAT));

    load_dc(0);
    fork
      send(8, "dc");
      recv(8, 1'b0, "dc");
    join

    load_sine(0);
    fork
      send(8, "sine");
      recv(8, 1'b0, "sine");
    join
    near("sine_F1_im", got_q[1][15:0], 16'hD667, 16);
    near("sine_F7_im", got_q[7][15:0], 16'h2999, 16);
    for (int k = 0; k < 8; k++) begin
      near($sformatf("sine_F%0d_re", k), got_q[k][31:16], 16'h0000, 8);
      if (k != 1 && k != 7) near($sformatf("sine_F%0d_im", k), got_q[k][15:0], 16'h0000, 8);
    end

    load_sine(0);
    load_impulse(8);
    fork
      send(16, "bp");
      recv(16, 1'b1, "bp");
    join
    bus.out_ready = 1'b1;

    load_dc(0);
    send(8, "abort");
    chk("abort_busy_calc", 32'(busy), 32'd1);
    chk("abort_in_ready_calc", 32'(bus.in_ready), 32'd0);
    repeat (5) @(posedge ck);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge ck);
    rst_n = 1'b1;
    load_impulse(0);
    fork
      send(8, "reimp");
      recv(8, 1'b0, "reimp");
    join
    chk("reimp_latency", 32'(first_v_cyc - acc_cyc[0] - 1), 32'(LAT));

    load_dc(0);
    load_sine(8);
    fork
      send(16, "b2b");
      recv(16, 1'b0, "b2b");
      begin
        int g = 0;
        while (!(busy && !bus.out_valid) && g < 500) begin
          @(negedge ck);
          g++;
        end
        w0 = 32'h0400_0400;
        w1 = 32'h1234_5678;
        w2 = 32'h0800_0800;
        w3 = 32'hC000_4000;
        g = 0;
        while (!bus.out_valid && g < 500) begin
          @(negedge ck);
          g++;
        end
        set_nominal_w();
      end
    join
    chk("b2b_period", 32'(acc_cyc[1] - acc_cyc[0]), 32'(PERIOD));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
